// File: rtl/nios_cpu_debug_slave_sysclk_gen_if.sv
// Command handshake bundle between the debug slave (master side) and the OCI core (slave side).
interface nios_cpu_debug_slave_sysclk_gen_if #(
  parameter int SR_W = 38,
  parameter int IR_W = 2
);
  localparam int N_CH = 2 ** IR_W;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] jdo;
  logic [N_CH-1:0] take_action;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output jdo,
    output take_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  jdo,
    input  take_action,
    output cmd_ready
  );
endinterface

// File: rtl/nios_cpu_debug_slave_sysclk_gen.sv
// System-clock half of the Nios II JTAG debug slave: update-strobe sync, command FIFO, action pulses.
// Defining DBG_SLAVE_PARITY_EN enables the odd-parity check on sr (sr MSB is the parity bit).
module nios_cpu_debug_slave_sysclk_gen #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_uir_i,
  input  logic                     vs_udr_i,
  input  logic [IR_W-1:0]          ir_in_i,
  input  logic [SR_W-1:0]          sr_i,
  input  logic                     ovf_clr_i,
  nios_cpu_debug_slave_sysclk_gen_if.master cmd_if,
  output logic [(2**IR_W)-1:0]     take_no_action_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     overflow_o,
  output logic                     parity_err_o
);
  localparam int N_CH = 2 ** IR_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int EW   = IR_W + SR_W;

  logic [SYNC_STAGES-1:0] uir_sync_q;
  logic [SYNC_STAGES-1:0] udr_sync_q;
  logic                   uir_prev_q;
  logic                   udr_prev_q;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SR_W-1:0] jdo_q, jdo_d;
  logic [N_CH-1:0] take_action_q, take_action_d;
  logic [N_CH-1:0] take_no_action_q, take_no_action_d;
  logic            overflow_q, overflow_d;

  logic            uir_rise_s;
  logic            udr_rise_s;
  logic            empty_s;
  logic            full_s;
  logic            pop_s;
  logic            accept_s;
  logic            push_s;
  logic            drop_s;
  logic            parity_ok_s;
  logic [EW-1:0]   head_s;

  // Synchroniser chains plus one edge-detect flop per strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      uir_prev_q <= 1'b0;
      udr_prev_q <= 1'b0;
    end else begin
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_i};
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_i};
      uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
    end
  end

  assign uir_rise_s = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
  assign udr_rise_s = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;

  // Pointers carry one extra wrap bit: full when only the wrap bits differ
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_s   = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_s    = ~empty_s & cmd_if.cmd_ready;
  assign accept_s = udr_rise_s & parity_ok_s;
  assign push_s   = accept_s & (~full_s | pop_s);
  assign drop_s   = accept_s & full_s & ~pop_s;

`ifdef DBG_SLAVE_PARITY_EN
  logic parity_err_q, parity_err_d;

  function automatic logic odd_parity_ok(input logic [SR_W-1:0] word);
    return ^word;
  endfunction

  assign parity_ok_s = odd_parity_ok(sr_i);

  // Sticky parity error; a reject in the clear cycle still sets it
  always_comb begin
    parity_err_d = parity_err_q;
    if (udr_rise_s && !parity_ok_s) begin
      parity_err_d = 1'b1;
    end else if (ovf_clr_i) begin
      parity_err_d = 1'b0;
    end else begin
      parity_err_d = parity_err_q;
    end
  end

  // Parity error register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_ok_s  = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  // Next-state for pointers, action pulses, jdo and sticky overflow
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    jdo_d            = jdo_q;
    take_action_d    = {N_CH{1'b0}};
    take_no_action_d = {N_CH{1'b0}};
    overflow_d       = overflow_q;

    if (pop_s) begin
      rd_ptr_d                            = rd_ptr_q + PW'(1);
      jdo_d                               = head_s[SR_W-1:0];
      take_action_d[head_s[EW-1 -: IR_W]] = 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (uir_rise_s) begin
      take_no_action_d[ir_in_i] = 1'b1;
    end else begin
      take_no_action_d = {N_CH{1'b0}};
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overflow_q       <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overflow_q       <= overflow_d;
    end
  end

  // Command storage; a full-and-popping write reuses the slot being read out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ir_in_i, sr_i};
    end
  end

  assign cmd_if.cmd_valid   = ~empty_s;
  assign cmd_if.cmd_ir      = head_s[EW-1 -: IR_W];
  assign cmd_if.jdo         = jdo_q;
  assign cmd_if.take_action = take_action_q;
  assign take_no_action_o   = take_no_action_q;
  assign fifo_level_o       = wr_ptr_q - rd_ptr_q;
  assign overflow_o         = overflow_q;
endmodule

// File: tb/tb_nios_cpu_debug_slave_sysclk_gen.sv
// Bench for nios_cpu_debug_slave_sysclk_gen: directed scenarios plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_nios_cpu_debug_slave_sysclk_gen;
  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int S     = 2;
  localparam int DEPTH = 4;
`ifdef DBG_SLAVE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } ent_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vs_uir = 1'b0;
  logic            vs_udr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            ovf_clr = 1'b0;
  logic [3:0]      tna;
  logic [2:0]      lvl;
  logic            ovf;
  logic            perr;

  int total_cnt = 0;
  int bad_cnt   = 0;
  bit rand_mode = 1'b0;

  nios_cpu_debug_slave_sysclk_gen_if #(.SR_W(SR_W), .IR_W(IR_W)) cmd_if ();

  nios_cpu_debug_slave_sysclk_gen #(
    .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(S), .DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .vs_uir_i         (vs_uir),
    .vs_udr_i         (vs_udr),
    .ir_in_i          (ir_in),
    .sr_i             (sr),
    .ovf_clr_i        (ovf_clr),
    .cmd_if           (cmd_if),
    .take_no_action_o (tna),
    .fifo_level_o     (lvl),
    .overflow_o       (ovf),
    .parity_err_o     (perr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: commands are a queue; a strobe rise takes effect S+1 edges after it is first sampled.
  ent_t       mq[$];
  logic [SR_W-1:0] m_jdo;
  logic [3:0] m_ta, m_tna;
  bit         m_ovf, m_perr;
  bit         uh [0:S+1];
  bit         vh [0:S+1];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_jdo = '0; m_ta = '0; m_tna = '0; m_ovf = 1'b0; m_perr = 1'b0;
      for (int i = 0; i <= S + 1; i++) begin uh[i] = 1'b0; vh[i] = 1'b0; end
    end else begin
      bit pop, urise, vrise, set_o, set_p;
      ent_t e;
      for (int i = S + 1; i > 0; i--) begin uh[i] = uh[i-1]; vh[i] = vh[i-1]; end
      uh[0] = vs_udr; vh[0] = vs_uir;
      urise = uh[S] && !uh[S+1];
      vrise = vh[S] && !vh[S+1];
      pop   = (mq.size() > 0) && cmd_if.cmd_ready;
      m_ta  = '0;
      set_o = 1'b0; set_p = 1'b0;
      if (pop) begin
        e = mq.pop_front();
        m_ta[e.ir] = 1'b1;
        m_jdo = e.sr;
      end
      if (urise) begin
        if (PAR_EN && ((^sr) == 1'b0)) set_p = 1'b1;
        else if (mq.size() == DEPTH) set_o = 1'b1;
        else mq.push_back('{ir: ir_in, sr: sr});
      end
      m_tna = '0;
      if (vrise) m_tna[ir_in] = 1'b1;
      if (set_o) m_ovf = 1'b1; else if (ovf_clr) m_ovf = 1'b0;
      if (set_p) m_perr = 1'b1; else if (ovf_clr) m_perr = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cmd_valid", cmd_if.cmd_valid, mq.size() > 0);
    if (mq.size() > 0) check("cmd_ir", cmd_if.cmd_ir, mq[0].ir);
    check("fifo_level", lvl, mq.size());
    check("jdo", cmd_if.jdo, m_jdo);
    check("take_action", cmd_if.take_action, m_ta);
    check("take_no_action", tna, m_tna);
    check("overflow", ovf, m_ovf);
    check("parity_err", perr, m_perr);
  end

  function automatic logic [SR_W-1:0] good(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] r;
    r = v;
    if (PAR_EN) r[SR_W-1] = ~(^v[SR_W-2:0]);
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rand_mode) begin
      cmd_if.cmd_ready = 1'($urandom_range(0, 1));
      ovf_clr = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic pulse_udr(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] data);
    tick(); ir_in = ir; sr = data; vs_udr = 1'b1;
    repeat (S + 3) tick();
    vs_udr = 1'b0;
    repeat (S + 3) tick();
  endtask

  task automatic pulse_uir(input logic [IR_W-1:0] ir);
    tick(); ir_in = ir; vs_uir = 1'b1;
    repeat (S + 3) tick();
    vs_uir = 1'b0;
    repeat (S + 3) tick();
  endtask

  task automatic clear_sticky();
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    tick();
  endtask

  task automatic wait_pulse(input bit use_tna, input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if ((use_tna ? tna : cmd_if.take_action) != 4'b0000) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  logic [SR_W-1:0] expv [0:3];

  task automatic drain(input int n);
    int idx;
    idx = 0;
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < 40 && idx < n; i++) begin
      tick();
      if (cmd_if.take_action != 4'b0000) begin
        check("drain_jdo", cmd_if.jdo, expv[idx]);
        idx++;
      end
    end
    check("drain_count", idx, n);
    cmd_if.cmd_ready = 1'b0;
    tick();
  endtask

  initial begin
    bit found;
    logic [SR_W-1:0] fv [0:4];
    logic [SR_W-1:0] nv;
    logic [SR_W-1:0] rsr;
    cmd_if.cmd_ready = 1'b0;

    // Reset held while vs_udr toggles
    repeat (2) tick();
    vs_udr = 1'b1; repeat (3) tick(); vs_udr = 1'b0; repeat (2) tick();
    check("rst_level", lvl, 3'd0);
    check("rst_valid", cmd_if.cmd_valid, 1'b0);
    check("rst_ta", cmd_if.take_action, 4'b0000);
    #2 reset_n = 1'b1;
    repeat (S + 3) tick();

    // Single command
    cmd_if.cmd_ready = 1'b1;
    tick(); ir_in = 2'b01; sr = 38'h2_1234_5678; vs_udr = 1'b1;
`ifdef DBG_SLAVE_PARITY_EN
    repeat (S + 6) tick();
    check("t2_perr", perr, 1'b1);
    check("t2_level", lvl, 3'd0);
`else
    wait_pulse(1'b0, S + 6, found);
    check("t2_seen", found, 1'b1);
    check("t2_ta", cmd_if.take_action, 4'b0010);
    check("t2_jdo", cmd_if.jdo, 38'h2_1234_5678);
    tick();
    check("t2_ta_off", cmd_if.take_action, 4'b0000);
    check("t2_valid_off", cmd_if.cmd_valid, 1'b0);
`endif
    vs_udr = 1'b0; cmd_if.cmd_ready = 1'b0;
    repeat (S + 3) tick();
    clear_sticky();

    // Overflow: five pushes into a depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      fv[i] = good(38'(i + 1) * 38'h13_5791 + 38'h5);
      pulse_udr(2'(i), fv[i]);
    end
    check("t3_level", lvl, 3'd4);
    check("t3_ovf", ovf, 1'b1);
    for (int i = 0; i < 4; i++) expv[i] = fv[i];
    drain(4);
    clear_sticky();
    check("t3_ovf_clr", ovf, 1'b0);

    // Full with a pop in the same cycle as the push
    for (int i = 0; i < 4; i++) begin
      fv[i] = good(38'($urandom));
      pulse_udr(2'(i), fv[i]);
    end
    nv = good(38'h1_5555_aaaa);
    tick(); ir_in = 2'b10; sr = nv; vs_udr = 1'b1;
    repeat (S) tick();
    cmd_if.cmd_ready = 1'b1;
    tick();
    cmd_if.cmd_ready = 1'b0;
    check("t4_ta", cmd_if.take_action, 4'b0001);
    check("t4_jdo", cmd_if.jdo, fv[0]);
    repeat (3) tick();
    vs_udr = 1'b0;
    repeat (S + 3) tick();
    check("t4_level", lvl, 3'd4);
    check("t4_ovf", ovf, 1'b0);
    expv[0] = fv[1]; expv[1] = fv[2]; expv[2] = fv[3]; expv[3] = nv;
    drain(4);

    // IR update pulse
    tick(); ir_in = 2'b11; vs_uir = 1'b1;
    wait_pulse(1'b1, S + 6, found);
    check("t5_seen", found, 1'b1);
    check("t5_tna", tna, 4'b1000);
    tick();
    check("t5_tna_off", tna, 4'b0000);
    check("t5_level", lvl, 3'd0);
    vs_uir = 1'b0;
    repeat (S + 3) tick();

    // Parity: even then odd overall parity
    pulse_udr(2'b00, 38'h0_0000_0003);
    check("t6_perr", perr, PAR_EN);
    check("t6_level_a", lvl, PAR_EN ? 3'd0 : 3'd1);
    pulse_udr(2'b01, 38'h0_0000_0001);
    check("t6_level_b", lvl, PAR_EN ? 3'd1 : 3'd2);
    if (PAR_EN) begin
      expv[0] = 38'h0_0000_0001;
      drain(1);
    end else begin
      expv[0] = 38'h0_0000_0003; expv[1] = 38'h0_0000_0001;
      drain(2);
    end
    clear_sticky();
    check("t6_perr_clr", perr, 1'b0);

    // Reset mid-operation drops queued commands
    pulse_udr(2'b10, good(38'h0_0bad_f00d));
    pulse_udr(2'b11, good(38'h0_0000_1234));
    @(negedge clk); #2 reset_n = 1'b0;
    repeat (3) tick();
    check("rst_mid_level", lvl, 3'd0);
    check("rst_mid_valid", cmd_if.cmd_valid, 1'b0);
    #2 reset_n = 1'b1;
    repeat (S + 3) tick();

    // Random traffic
    rand_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_uir(2'($urandom_range(0, 3)));
      end else begin
        rsr = 38'({$urandom, $urandom});
        if ($urandom_range(0, 3) != 0) rsr = good(rsr);
        pulse_udr(2'($urandom_range(0, 3)), rsr);
      end
    end
    rand_mode = 1'b0;
    ovf_clr = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    repeat (12) tick();
    cmd_if.cmd_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
